// File: rtl/anti_theft_zone_fsm_pkg.sv
// rtl/anti_theft_zone_fsm_pkg.sv - shared states and default delays for the multi-zone anti-theft controller
package anti_theft_pkg;

  typedef enum logic [2:0] {
    DISARMED,
    WAIT_CLOSE,
    ARMING,
    ARMED,
    TRIGGERED,
    ALARM,
    ALARM_HOLD
  } state_t;

  // Default delays in seconds, for integrators wiring fixed values
  localparam int unsigned DEF_ARM_DELAY       = 6;
  localparam int unsigned DEF_DRIVER_DELAY    = 8;
  localparam int unsigned DEF_PASSENGER_DELAY = 15;
  localparam int unsigned DEF_ALARM_ON        = 10;

endpackage

// File: rtl/anti_theft_zone_fsm_countdown.sv
// rtl/anti_theft_zone_fsm_countdown.sv - loadable seconds countdown, saturating at zero
module anti_theft_countdown #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          expired
);

  // Load wins over a coincident tick so a fresh delay always starts full
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/anti_theft_zone_fsm.sv
// rtl/anti_theft_zone_fsm.sv - multi-zone vehicle anti-theft controller with integrated countdown
module anti_theft_zone_fsm
  import anti_theft_pkg::*;
#(
  parameter int N_ZONES     = 2,
  parameter int TW          = 4,
  parameter int ALARM_REARM = 1,
  localparam int ZW         = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ignition,
  input  logic [N_ZONES-1:0]    door,
  input  logic [N_ZONES-1:0]    zone_enable,
  input  logic                  one_hz_enable,
  input  logic [TW-1:0]         t_arm_delay,
  input  logic [N_ZONES*TW-1:0] t_entry_delay,
  input  logic [TW-1:0]         t_alarm_on,
  output logic [TW-1:0]         timer_value,
  output logic                  status_led,
  output logic                  siren_enable,
  output logic                  armed,
  output logic [ZW-1:0]         trig_zone
);

  function automatic logic [ZW-1:0] lowest_zone(input logic [N_ZONES-1:0] v);
    logic [ZW-1:0] r;
    r = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      if (v[i]) r = ZW'(i);
    end
    return r;
  endfunction

  state_t            state, next_state;
  logic              load;
  logic [TW-1:0]     load_val;
  logic              expired;
  logic [N_ZONES-1:0] open_vec;
  logic              open_any;
  logic [ZW-1:0]     sel_zone;
  logic [TW-1:0]     sel_entry;

  assign open_vec  = door & zone_enable;
  assign open_any  = |open_vec;
  assign sel_zone  = lowest_zone(open_vec);
  assign sel_entry = t_entry_delay[int'(sel_zone)*TW +: TW];

  anti_theft_countdown #(.TW(TW)) u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (one_hz_enable),
    .count    (timer_value),
    .expired  (expired)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = t_arm_delay;
    if (ignition && (state != DISARMED)) begin
      next_state = DISARMED;
    end else begin
      case (state)
        DISARMED: begin
          if (!ignition && door[0]) next_state = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (!door[0]) begin
            next_state = ARMING;
            load       = 1'b1;
          end
        end
        ARMING: begin
          // Any disturbance restarts the exit delay from the top
          if (open_any || door[0]) begin
            load = 1'b1;
          end else if (expired) begin
            next_state = ARMED;
          end
        end
        ARMED: begin
          if (open_any) begin
            next_state = TRIGGERED;
            load       = 1'b1;
            load_val   = sel_entry;
          end
        end
        TRIGGERED: begin
          if (expired) next_state = ALARM;
        end
        ALARM: begin
          if ((ALARM_REARM != 0) && !open_any) begin
            next_state = ALARM_HOLD;
            load       = 1'b1;
            load_val   = t_alarm_on;
          end
        end
        ALARM_HOLD: begin
          if (open_any) begin
            next_state = ALARM;
          end else if (expired) begin
            next_state = ARMED;
          end
        end
        default: next_state = ARMED;
      endcase
    end
  end

  // Outputs follow the state being entered so they line up with the new state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARMED;
      status_led   <= 1'b0;
      siren_enable <= 1'b0;
      armed        <= 1'b1;
      trig_zone    <= '0;
    end else begin
      state        <= next_state;
      armed        <= (next_state == ARMED);
      siren_enable <= (next_state == ALARM) || (next_state == ALARM_HOLD);
      case (next_state)
        ARMED: begin
          if (state != ARMED)     status_led <= 1'b0;
          else if (one_hz_enable) status_led <= ~status_led;
        end
        TRIGGERED, ALARM, ALARM_HOLD: status_led <= 1'b1;
        default:                      status_led <= 1'b0;
      endcase
      if ((state == ARMED) && (next_state == TRIGGERED)) trig_zone <= sel_zone;
    end
  end

endmodule

// File: tb/tb_anti_theft_zone_fsm.sv
// tb/tb_anti_theft_zone_fsm.sv - directed scoreboard bench for the multi-zone anti-theft controller
module tb_anti_theft_zone_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       ignition;
  logic [1:0] door;
  logic [1:0] zone_enable;
  logic       one_hz_enable;
  logic [3:0] t_arm_delay;
  logic [7:0] t_entry_delay;
  logic [3:0] t_alarm_on;

  logic [3:0] timer_value, timer1;
  logic       status_led, led1;
  logic       siren_enable, siren1;
  logic       armed, armed1;
  logic       trig_zone, trig1;

  always #5 clk = ~clk;

  anti_theft_zone_fsm #(.N_ZONES(2), .TW(4), .ALARM_REARM(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ignition      (ignition),
    .door          (door),
    .zone_enable   (zone_enable),
    .one_hz_enable (one_hz_enable),
    .t_arm_delay   (t_arm_delay),
    .t_entry_delay (t_entry_delay),
    .t_alarm_on    (t_alarm_on),
    .timer_value   (timer_value),
    .status_led    (status_led),
    .siren_enable  (siren_enable),
    .armed         (armed),
    .trig_zone     (trig_zone)
  );

  anti_theft_zone_fsm #(.N_ZONES(2), .TW(4), .ALARM_REARM(0)) dut_latch (
    .clk           (clk),
    .rst           (rst),
    .ignition      (ignition),
    .door          (door),
    .zone_enable   (zone_enable),
    .one_hz_enable (one_hz_enable),
    .t_arm_delay   (t_arm_delay),
    .t_entry_delay (t_entry_delay),
    .t_alarm_on    (t_alarm_on),
    .timer_value   (timer1),
    .status_led    (led1),
    .siren_enable  (siren1),
    .armed         (armed1),
    .trig_zone     (trig1)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%0h required=expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst           = 1'b1;
    ignition      = 1'b0;
    door          = 2'b00;
    zone_enable   = 2'b11;
    one_hz_enable = 1'b0;
    t_arm_delay   = 4'd6;
    t_entry_delay = {4'd15, 4'd8};
    t_alarm_on    = 4'd10;
    step();
    step();

    // Reset state
    expect_val("rst_armed", 1); expect_val("rst_timer", 0); expect_val("rst_led", 0);
    expect_val("rst_siren", 0); expect_val("rst_trig", 0);
    check(armed); check(timer_value); check(status_led); check(siren_enable); check(trig_zone);
    rst = 1'b0;

    // Passenger door trigger, siren 15 ticks + 1 cycle later
    door = 2'b10;
    expect_val("t1_timer", 15); expect_val("t1_trig", 1); expect_val("t1_armed", 0); expect_val("t1_led", 1);
    step();
    check(timer_value); check(trig_zone); check(armed); check(status_led);
    ticks(14);
    expect_val("t1_timer14", 1); check(timer_value);
    tick();
    expect_val("t1_timer15", 0); expect_val("t1_siren_early", 0);
    check(timer_value); check(siren_enable);
    step();
    expect_val("t1_siren", 1); check(siren_enable);

    // Alarm hold, re-entry on reopen, re-arm after hold expires
    door = 2'b00;
    step();
    expect_val("t4_hold_timer", 10); expect_val("t4_hold_siren", 1);
    check(timer_value); check(siren_enable);
    ticks(5);
    door = 2'b10;
    step();
    door = 2'b00;
    step();
    expect_val("t4_reload", 10); check(timer_value);
    ticks(9);
    expect_val("t4_timer9", 1); check(timer_value);
    tick();
    expect_val("t4_siren_held", 1); expect_val("t4_not_armed", 0);
    check(siren_enable); check(armed);
    step();
    expect_val("t4_rearm", 1); expect_val("t4_siren_off", 0); expect_val("t4_led_phase", 0);
    check(armed); check(siren_enable); check(status_led);
    ticks(20);
    expect_val("t4_latch_siren", 1); expect_val("t4_led_even", 0);
    check(siren1); check(status_led);
    tick();
    expect_val("t4_led_odd", 1); check(status_led);

    // Bypassed zone ignored; simultaneous doors pick zone 0; tick coincident with load
    zone_enable = 2'b01;
    door        = 2'b10;
    step();
    step();
    expect_val("t5_bypass", 1); check(armed);
    zone_enable   = 2'b11;
    door          = 2'b11;
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
    expect_val("t6_full_delay", 8); expect_val("t5_trig0", 0); check(timer_value); check(trig_zone);
    door = 2'b10;
    tick();
    expect_val("t5_no_reload", 7); expect_val("t5_trig_held", 0); check(timer_value); check(trig_zone);

    // Ignition disarms
    ignition = 1'b1;
    door     = 2'b00;
    step();
    expect_val("dis_armed", 0); expect_val("dis_siren", 0); expect_val("dis_led", 0);
    check(armed); check(siren_enable); check(status_led);

    // Arming sequence with reload on reopen
    ignition = 1'b0;
    door     = 2'b01;
    step();
    door = 2'b00;
    step();
    expect_val("t3_load", 6); check(timer_value);
    ticks(3);
    expect_val("t3_count3", 3); check(timer_value);
    door = 2'b10;
    tick();
    door = 2'b00;
    step();
    expect_val("t3_reload", 6); check(timer_value);
    ticks(5);
    expect_val("t3_not_yet", 0); check(armed);
    tick();
    expect_val("t3_zero_not_armed", 0); check(armed);
    step();
    expect_val("t3_armed", 1); expect_val("t3_led0", 0); check(armed); check(status_led);

    // Driver door in ARMED then ignition after 3 ticks
    door = 2'b01;
    step();
    expect_val("t2_timer", 8); expect_val("t2_trig", 0); check(timer_value); check(trig_zone);
    ticks(3);
    expect_val("t2_timer3", 5); expect_val("t2_siren", 0); check(timer_value); check(siren_enable);
    ignition = 1'b1;
    step();
    expect_val("t2_armed", 0); expect_val("t2_led", 0); expect_val("t2_siren_off", 0);
    check(armed); check(status_led); check(siren_enable);

    // Reset mid-countdown with a door held open
    ignition = 1'b0;
    door     = 2'b10;
    rst      = 1'b1;
    step();
    expect_val("rst2_armed", 1); expect_val("rst2_timer", 0); check(armed); check(timer_value);
    rst = 1'b0;
    step();
    expect_val("rst2_retrig", 0); expect_val("rst2_zone", 1); expect_val("rst2_timer15", 15);
    check(armed); check(trig_zone); check(timer_value);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
